regbank_file: RTL and testbench
===============================

Name: regbank_file

Overview:
- 32 x 32-bit MIPS general-purpose register storage: one synchronous write port, two combinational read ports.
- Holds the architectural register state.
- Each read port selects one of the 32 register words through a 5-bit address (32:1 word select).
- Write side is driven by the writeback stage; read data goes to decode/execute.

Parameters:
- WIDTH, 32, register word width in bits.
- NREGS, 32, number of registers; fixed at 32 (address width 5). Other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write enable, sampled on rising clk.
- wa  input  5  write address.
- wd  input  WIDTH  write data.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- wr_count  output  8  saturating count of committed non-zero-register writes (debug).

Behaviour:
- Storage: registers r1..r31, WIDTH bits each.
- r0 is not stored: reads of address 0 always return 0, and writes to address 0 are discarded.
- Reset: on a rising clk with reset=1, r1..r31 become 0 and wr_count becomes 0, all in the same cycle.
  - A write presented in the reset cycle is ignored; reset wins.
  - Reset mid-stream is legal; the following cycle behaves as freshly reset.
- Write: on a rising clk with reset=0, we=1 and wa!=0, r[wa] <= wd.
  - Result is visible on rd1/rd2 in the cycle after the edge (1-cycle write latency).
  - we=0: no register changes.
- Read: rd1 = r[ra1] and rd2 = r[ra2], purely combinational from the current state, with no clock latency.
  - ra1==ra2 is legal; both ports return the same value.
- Read-during-write (same cycle, ra==wa), without the optional feature: rd returns the OLD value; the new value appears the next cycle.
- wr_count: increments by 1 on each committed write (we=1, wa!=0, reset=0).
  - Saturates at 255; it never wraps.
  - Writes to r0 do not count.
- Output reset values: after reset, rd1=rd2=0 for any address, and wr_count=0.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined: internal write-through forwarding.
  - If we=1, wa!=0, reset=0 and ra1==wa, then rd1=wd in the same cycle; likewise rd2 when ra2==wa.
  - Address 0 is never forwarded.
  - This lets writeback in the first half-cycle feed decode in the same cycle.
- Not defined: no forwarding logic is present; read-during-write returns the old value as stated above.
- Storage timing and wr_count behaviour are identical in both builds.

Decomposition:
- Shared package regbank_pkg:
  - REG_W=32, REG_AW=5, REG_ZERO=5'd0.
  - typedef reg_addr_t (logic [4:0]).
  - typedef reg_word_t (logic [31:0]).
- Natural sub-module: regbank_wdec.
  - 5-to-32 one-hot write decoder gated by we.
  - Bit 0 is forced low.
  - Outputs per-register enables to the 31 enabled flops.
- Read selection uses the team's existing 32:1 word-select structure; no new read sub-module.

Test Plan:
- Reset clears: preload r5=0xDEADBEEF, assert reset 1 cycle, then ra1=5 -> rd1=0x00000000, wr_count=0.
- Basic write/read: we=1, wa=7, wd=0x12345678 at edge N; ra1=7 at N+1 -> rd1=0x12345678, wr_count=1.
- r0 hardwired: we=1, wa=0, wd=0xFFFFFFFF; ra1=0 -> rd1=0, and wr_count unchanged.
- Read-during-write: r3=0x11, then write wa=3, wd=0x22 with ra2=3 the same cycle:
  - Without REGBANK_BYPASS_EN -> rd2=0x11 that cycle, 0x22 next cycle.
  - With REGBANK_BYPASS_EN -> rd2=0x22 immediately.
- Reset beats write: reset=1, we=1, wa=9, wd=0xABCD in the same cycle -> r9 reads 0 next cycle, wr_count=0.
- Saturation and sweep: write r1..r31 with value = index*0x01010101, repeated 9 times (279 writes) -> every register reads back its pattern on both ports, and wr_count=255.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and constants for the MIPS general-purpose register bank.
package regbank_pkg;

    localparam int REG_W  = 32;
    localparam int REG_AW = 5;
    localparam int REG_N  = 32;

    localparam logic [REG_AW-1:0] REG_ZERO     = 5'd0;
    localparam logic [7:0]        WR_COUNT_MAX = 8'hFF;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]  reg_word_t;

    function automatic logic is_zero(input reg_addr_t a);
        return a == REG_ZERO;
    endfunction

endpackage

// File: rtl/regbank_wdec.sv
// One-hot write-enable decoder for the register bank; r0 never gets an enable.
module regbank_wdec
    import regbank_pkg::*;
(
    input  logic             we,
    input  logic [4:0]       wa,
    output logic [REG_N-1:0] wen
);

    always_comb begin
        wen = '0;
        if (we && !is_zero(wa)) begin
            wen[wa] = 1'b1;
        end
        wen[0] = 1'b0;
    end

endmodule

// File: rtl/regbank_file.sv
// 32 x WIDTH register bank: one synchronous write port, two combinational read ports.
// Optional same-cycle write-through forwarding when REGBANK_BYPASS_EN is defined.
module regbank_file
    import regbank_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [4:0]       wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [7:0]       wr_count
);

    logic [WIDTH-1:0] regs  [1:NREGS-1];
    logic [WIDTH-1:0] words [0:NREGS-1];
    logic [REG_N-1:0] wen;
    logic             commit;

    regbank_wdec u_wdec (
        .we  (we),
        .wa  (wa),
        .wen (wen)
    );

    // wen[0] is always low, so any set bit means a real register is written
    assign commit = ~reset & (|wen);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (wen[i]) begin
                    regs[i] <= wd;
                end
            end
            if (commit && wr_count != WR_COUNT_MAX) begin
                wr_count <= wr_count + 8'd1;
            end
        end
    end

    always_comb begin
        words[0] = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            words[i] = regs[i];
        end
    end

    always_comb begin
        rd1 = words[ra1];
        rd2 = words[ra2];
`ifdef REGBANK_BYPASS_EN
        if (commit && ra1 == wa) begin
            rd1 = wd;
        end
        if (commit && ra2 == wa) begin
            rd2 = wd;
        end
`endif
    end

endmodule

// File: tb/tb_regbank_file.sv
// Scoreboard bench for regbank_file; follows REGBANK_BYPASS_EN for read-during-write expectations.
module tb_regbank_file;

    logic        clk = 1'b0;
    logic        reset, we;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd, rd1, rd2;
    logic [7:0]  wr_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mregs [32];
    int          mcnt;
    logic [31:0] exp_q [$];

    regbank_file #(.WIDTH(32), .NREGS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a, input logic r, input logic w,
                                          input logic [4:0] a_w, input logic [31:0] d);
        if (a == 5'd0) return 32'h0;
`ifdef REGBANK_BYPASS_EN
        if (!r && w && a == a_w) return d;
`endif
        return mregs[a];
    endfunction

    // One clock: drive, push expectations, compare at negedge, update model at posedge.
    task automatic cyc(input string tag, input logic r, input logic w, input logic [4:0] a_w,
                       input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2,
                       input bit k, input logic [31:0] k1, input logic [31:0] k2,
                       input logic [7:0] kc);
        reset = r; we = w; wa = a_w; wd = d; ra1 = a1; ra2 = a2;
        if (k) begin
            exp_q.push_back(k1);
            exp_q.push_back(k2);
            exp_q.push_back({24'h0, kc});
        end else begin
            exp_q.push_back(mread(a1, r, w, a_w, d));
            exp_q.push_back(mread(a2, r, w, a_w, d));
            exp_q.push_back(32'(mcnt));
        end
        @(negedge clk);
        check({tag, "/rd1"}, rd1, exp_q.pop_front());
        check({tag, "/rd2"}, rd2, exp_q.pop_front());
        check({tag, "/cnt"}, {24'h0, wr_count}, exp_q.pop_front());
        @(posedge clk);
        if (r) begin
            foreach (mregs[i]) mregs[i] = 32'h0;
            mcnt = 0;
        end else if (w && a_w != 5'd0) begin
            mregs[a_w] = d;
            if (mcnt < 255) mcnt++;
        end
        #1;
    endtask

    task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] a1, input logic [4:0] a2);
        cyc(tag, 1'b0, 1'b1, a, d, a1, a2, 1'b0, 32'h0, 32'h0, 8'h0);
    endtask

    task automatic kr(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] k1, input logic [31:0] k2, input logic [7:0] kc);
        cyc(tag, 1'b0, 1'b0, 5'd0, 32'h0, a1, a2, 1'b1, k1, k2, kc);
    endtask

    initial begin
        logic [31:0] rdw_now;
        logic [4:0]  ai, bi;

        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        @(posedge clk); #1;
        foreach (mregs[i]) mregs[i] = 32'h0;
        mcnt = 0;

        kr("rst0", 5'd0, 5'd17, 32'h0, 32'h0, 8'd0);

        wr("pre5", 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        kr("pre5_rd", 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 8'd1);
        cyc("rst1", 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 32'h0, 32'h0, 8'h0);
        kr("rst_clr", 5'd5, 5'd5, 32'h0, 32'h0, 8'd0);

        wr("w7", 5'd7, 32'h12345678, 5'd0, 5'd0);
        kr("wr_basic", 5'd7, 5'd0, 32'h12345678, 32'h0, 8'd1);

        cyc("w0", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 1'b0, 32'h0, 32'h0, 8'h0);
        kr("r0_hard", 5'd0, 5'd7, 32'h0, 32'h12345678, 8'd1);

        wr("w3", 5'd3, 32'h11, 5'd1, 5'd2);
`ifdef REGBANK_BYPASS_EN
        rdw_now = 32'h22;
`else
        rdw_now = 32'h11;
`endif
        cyc("rdw", 1'b0, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 1'b1, rdw_now, rdw_now, 8'd2);
        kr("rdw_next", 5'd3, 5'd3, 32'h22, 32'h22, 8'd3);

        cyc("rst_wr", 1'b1, 1'b1, 5'd9, 32'hABCD, 5'd9, 5'd3, 1'b0, 32'h0, 32'h0, 8'h0);
        kr("rst_beats_wr", 5'd9, 5'd3, 32'h0, 32'h0, 8'd0);

        for (int p = 0; p < 9; p++) begin
            for (int i = 1; i < 32; i++) begin
                ai = 5'(i);
                wr("sweep", ai, 32'(i) * 32'h01010101, 5'($urandom_range(0, 31)), ai);
            end
        end
        for (int i = 0; i < 32; i++) begin
            ai = 5'(i);
            bi = 5'(31 - i);
            kr("readback", ai, bi, 32'(i) * 32'h01010101, 32'(31 - i) * 32'h01010101, 8'd255);
        end

        for (int n = 0; n < 40; n++) begin
            cyc("rand", 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                1'b0, 32'h0, 32'h0, 8'h0);
        end
        kr("sat_hold", 5'd0, 5'd0, 32'h0, 32'h0, 8'd255);

        cyc("rst_mid", 1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 1'b0, 32'h0, 32'h0, 8'h0);
        kr("rst_mid_clr", 5'd1, 5'd31, 32'h0, 32'h0, 8'd0);
        wr("post_rst", 5'd31, 32'hCAFEF00D, 5'd31, 5'd30);
        kr("post_rst_rd", 5'd31, 5'd30, 32'hCAFEF00D, 32'h0, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
